// File: rtl/flb_pkg.sv
// Shared types and constants for the FLB band calibration controller.
package flb_pkg;

    localparam int unsigned BAND_W   = 8;
    localparam int unsigned SETTLE_W = 8;

    // Mid-scale code for a band of width w: only the MSB set.
    function automatic logic [31:0] mid_code(input int unsigned w);
        return 32'(1) << (w - 1);
    endfunction

    localparam logic [BAND_W-1:0] BAND_MID = BAND_W'(mid_code(BAND_W));

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StReq,
        StWait,
        StDone,
        StErr,
        StMan
    } flb_cal_state_e;

endpackage

// File: rtl/flb_cal_timer.sv
// Loadable saturating down-counter; zero marks expiry of the current settle or timeout interval.
module flb_cal_timer #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/flb_band_cal_ctrl.sv
// SAR band calibration controller: searches the FLB coarse band MSB-first against an external
// frequency comparator, holding the loop during the search and releasing it when done.
module flb_band_cal_ctrl #(
    parameter int unsigned BAND_W   = flb_pkg::BAND_W,
    parameter int unsigned SETTLE_W = flb_pkg::SETTLE_W,
    parameter int unsigned TMO_CYC  = 1023
) (
    input  logic                ref_clk,
    input  logic                csr_flb_rst_n,
    input  logic                csr_flb_cal_start,
    input  logic [SETTLE_W-1:0] csr_flb_cal_settle,
    input  logic                csr_flb_cal_man_on,
    input  logic [BAND_W-1:0]   csr_flb_cal_man_band,
    input  logic                meas_valid,
    input  logic                meas_fast,
    output logic                meas_req,
    output logic [BAND_W-1:0]   band,
    output logic                dlf_hold,
    output logic                sdm_gate,
    output logic                cal_busy,
    output logic                cal_done,
    output logic                cal_err
);

    import flb_pkg::*;

    localparam int unsigned IDX_W = (BAND_W > 1) ? $clog2(BAND_W) : 1;
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    localparam int unsigned TMR_W = (SETTLE_W > TMO_W) ? SETTLE_W : TMO_W;

    localparam logic [BAND_W-1:0] MID_CODE = BAND_W'(mid_code(BAND_W));
    localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(BAND_W - 1);
    localparam logic [TMR_W-1:0]  TMO_LOAD = TMR_W'(TMO_CYC - 1);

    flb_cal_state_e    state_q;
    logic              start_q;
    logic              start_prev_q;
    logic [BAND_W-1:0] result_q;
    logic [IDX_W-1:0]  idx_q;

    logic              start_edge;
    logic              can_start;
    logic              go_first;
    logic              go_next;
    logic [BAND_W-1:0] bit_cur;
    logic [BAND_W-1:0] bit_nxt;
    logic [BAND_W-1:0] trial;
    logic [BAND_W-1:0] res_next;
    logic              tmr_load;
    logic              tmr_dec;
    logic              tmr_zero;
    logic [TMR_W-1:0]  tmr_load_val;
    logic [TMR_W-1:0]  settle_load;

    always_ff @(posedge ref_clk or negedge csr_flb_rst_n) begin
        if (!csr_flb_rst_n) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            start_q      <= csr_flb_cal_start;
            start_prev_q <= start_q;
        end
    end

    assign start_edge = start_q & ~start_prev_q;
    assign can_start  = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
    assign go_first   = !csr_flb_cal_man_on && can_start && start_edge;
    assign go_next    = !csr_flb_cal_man_on && (state_q == StWait) && meas_valid
                        && (idx_q != '0);

    assign bit_cur  = BAND_W'(1) << idx_q;
    assign bit_nxt  = BAND_W'(1) << (idx_q - IDX_W'(1));
    assign trial    = result_q | bit_cur;
    // A fast DCO means the trial bit overshoots the target, so it is dropped.
    assign res_next = meas_fast ? result_q : trial;

    // A settle CSR of 0 still gives one settle cycle.
    assign settle_load = (csr_flb_cal_settle == '0) ? '0
                       : TMR_W'(csr_flb_cal_settle - SETTLE_W'(1));

    always_comb begin
        tmr_load     = go_first || go_next || (state_q == StReq);
        tmr_load_val = (state_q == StReq) ? TMO_LOAD : settle_load;
        tmr_dec      = (state_q == StSettle) || (state_q == StWait);
    end

    flb_cal_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (ref_clk),
        .rst_n    (csr_flb_rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge ref_clk or negedge csr_flb_rst_n) begin
        if (!csr_flb_rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            idx_q    <= IDX_TOP;
            band     <= MID_CODE;
            meas_req <= 1'b0;
            dlf_hold <= 1'b1;
            sdm_gate <= 1'b0;
            cal_busy <= 1'b0;
            cal_done <= 1'b0;
            cal_err  <= 1'b0;
        end else begin
            meas_req <= 1'b0;
            if (csr_flb_cal_man_on) begin
                state_q  <= StMan;
                band     <= csr_flb_cal_man_band;
                dlf_hold <= 1'b0;
                sdm_gate <= 1'b1;
                cal_busy <= 1'b0;
                cal_done <= 1'b0;
                cal_err  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone, StErr: begin
                        if (start_edge) begin
                            state_q  <= StSettle;
                            result_q <= '0;
                            idx_q    <= IDX_TOP;
                            band     <= MID_CODE;
                            dlf_hold <= 1'b1;
                            sdm_gate <= 1'b0;
                            cal_busy <= 1'b1;
                            cal_done <= 1'b0;
                            cal_err  <= 1'b0;
                        end
                    end
                    StSettle: begin
                        if (tmr_zero) begin
                            state_q  <= StReq;
                            meas_req <= 1'b1;
                        end
                    end
                    StReq: begin
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (meas_valid) begin
                            result_q <= res_next;
                            if (idx_q != '0) begin
                                idx_q   <= idx_q - IDX_W'(1);
                                band    <= res_next | bit_nxt;
                                state_q <= StSettle;
                            end else begin
                                band     <= res_next;
                                state_q  <= StDone;
                                cal_busy <= 1'b0;
                                cal_done <= 1'b1;
                                dlf_hold <= 1'b0;
                                sdm_gate <= 1'b1;
                            end
                        end else if (tmr_zero) begin
                            state_q  <= StErr;
                            band     <= MID_CODE;
                            cal_busy <= 1'b0;
                            cal_err  <= 1'b1;
                            dlf_hold <= 1'b1;
                            sdm_gate <= 1'b0;
                        end
                    end
                    StMan: begin
                        // Leaving manual keeps the last manual band on the FLB.
                        state_q  <= StIdle;
                        dlf_hold <= 1'b1;
                        sdm_gate <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flb_band_cal_ctrl.sv
// Bench for flb_band_cal_ctrl: threshold comparator responder plus directed and random searches.
module tb_flb_band_cal_ctrl;

    localparam int TMO = 1023;

    logic       ref_clk              = 1'b0;
    logic       csr_flb_rst_n        = 1'b1;
    logic       csr_flb_cal_start    = 1'b0;
    logic [7:0] csr_flb_cal_settle   = 8'd0;
    logic       csr_flb_cal_man_on   = 1'b0;
    logic [7:0] csr_flb_cal_man_band = 8'd0;
    logic       meas_valid           = 1'b0;
    logic       meas_fast            = 1'b0;
    logic       meas_req;
    logic [7:0] band;
    logic       dlf_hold;
    logic       sdm_gate;
    logic       cal_busy;
    logic       cal_done;
    logic       cal_err;

    int         errors  = 0;
    int         checks  = 0;
    bit         resp_on = 1'b1;
    bit         noise   = 1'b0;
    int         d_cyc   = 3;
    logic [7:0] target  = 8'h00;

    int         t_req;
    int         t_err;
    int         reqs;
    int         glitch;

    always #5 ref_clk = ~ref_clk;

    flb_band_cal_ctrl #(
        .BAND_W   (8),
        .SETTLE_W (8),
        .TMO_CYC  (TMO)
    ) dut (
        .ref_clk              (ref_clk),
        .csr_flb_rst_n        (csr_flb_rst_n),
        .csr_flb_cal_start    (csr_flb_cal_start),
        .csr_flb_cal_settle   (csr_flb_cal_settle),
        .csr_flb_cal_man_on   (csr_flb_cal_man_on),
        .csr_flb_cal_man_band (csr_flb_cal_man_band),
        .meas_valid           (meas_valid),
        .meas_fast            (meas_fast),
        .meas_req             (meas_req),
        .band                 (band),
        .dlf_hold             (dlf_hold),
        .sdm_gate             (sdm_gate),
        .cal_busy             (cal_busy),
        .cal_done             (cal_done),
        .cal_err              (cal_err)
    );

    // Reference: the largest code whose trial never makes a threshold comparator report fast.
    function automatic logic [7:0] ref_sar(input logic [7:0] tgt);
        int r;
        r = 0;
        for (int i = 7; i >= 0; i--) begin
            if (r + (1 << i) <= int'(tgt)) r += (1 << i);
        end
        return r[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Comparator: answers d_cyc cycles after each request; noise adds ignored strobes.
    initial begin
        forever begin
            @(posedge ref_clk);
            #1;
            if (resp_on && meas_req === 1'b1) begin
                if (noise) begin
                    meas_valid = 1'b1;
                    meas_fast  = 1'($urandom);
                end
                for (int k = 0; k < d_cyc; k++) begin
                    @(posedge ref_clk);
                    #1;
                    meas_valid = 1'b0;
                end
                meas_valid = 1'b1;
                meas_fast  = (band > target);
                @(posedge ref_clk);
                #1;
                if (noise) begin
                    meas_fast = ~meas_fast;
                    @(posedge ref_clk);
                    #1;
                end
                meas_valid = 1'b0;
            end
        end
    end

    task automatic run_cal(input logic [7:0] tgt, input int settle, input int d, input bit nz,
                           input string tag);
        int   t0;
        int   t_req1;
        int   t_done;
        int   nreq;
        int   s_eff;
        logic prev_hold;
        logic hold_before;
        logic hold_at_done;
        logic gate_at_done;
        s_eff        = (settle == 0) ? 1 : settle;
        target       = tgt;
        d_cyc        = d;
        noise        = nz;
        resp_on      = 1'b1;
        csr_flb_cal_settle = 8'(settle);
        t0           = -1;
        t_req1       = -1;
        t_done       = -1;
        nreq         = 0;
        prev_hold    = 1'b1;
        hold_before  = 1'b0;
        hold_at_done = 1'b1;
        gate_at_done = 1'b0;
        @(negedge ref_clk);
        csr_flb_cal_start = 1'b1;
        for (int cyc = 0; cyc < 4000 && t_done < 0; cyc++) begin
            @(negedge ref_clk);
            if (t0 < 0 && cal_busy) begin
                t0 = cyc;
                if (!nz) csr_flb_cal_start = 1'b0;
            end
            if (meas_req) begin
                nreq++;
                if (t_req1 < 0) t_req1 = cyc;
            end
            if (nz && t0 >= 0 && nreq < 7 && (cyc % 5) == 0) csr_flb_cal_start = ~csr_flb_cal_start;
            if (cal_done && t0 >= 0) begin
                t_done       = cyc;
                hold_before  = prev_hold;
                hold_at_done = dlf_hold;
                gate_at_done = sdm_gate;
            end
            prev_hold = dlf_hold;
        end
        csr_flb_cal_start = 1'b0;
        check({tag, "_done"}, 32'(cal_done), 32'd1);
        check({tag, "_latency"}, 32'(t_done - t0), 32'(8 * (s_eff + 1 + d)));
        check({tag, "_settle_len"}, 32'(t_req1 - t0), 32'(s_eff));
        check({tag, "_req_pulses"}, 32'(nreq), 32'd8);
        check({tag, "_band"}, 32'(band), 32'(ref_sar(tgt)));
        check({tag, "_hold_before"}, 32'(hold_before), 32'd1);
        check({tag, "_hold_at_done"}, 32'(hold_at_done), 32'd0);
        check({tag, "_gate_at_done"}, 32'(gate_at_done), 32'd1);
        check({tag, "_busy"}, 32'(cal_busy), 32'd0);
        check({tag, "_err"}, 32'(cal_err), 32'd0);
        repeat (4) @(negedge ref_clk);
        noise = 1'b0;
    endtask

    task automatic start_until_reqs(input int n);
        @(negedge ref_clk);
        csr_flb_cal_start = 1'b1;
        reqs = 0;
        for (int cyc = 0; cyc < 600 && reqs < n; cyc++) begin
            @(negedge ref_clk);
            if (cal_busy) csr_flb_cal_start = 1'b0;
            if (meas_req) reqs++;
        end
        csr_flb_cal_start = 1'b0;
    endtask

    initial begin
        #1 csr_flb_rst_n = 1'b0;
        #2;
        check("rst_band", 32'(band), 32'h80);
        check("rst_req", 32'(meas_req), 32'd0);
        check("rst_hold", 32'(dlf_hold), 32'd1);
        check("rst_gate", 32'(sdm_gate), 32'd0);
        check("rst_busy", 32'(cal_busy), 32'd0);
        check("rst_done", 32'(cal_done), 32'd0);
        check("rst_err", 32'(cal_err), 32'd0);
        repeat (3) @(negedge ref_clk);
        csr_flb_rst_n = 1'b1;
        repeat (3) @(negedge ref_clk);
        check("idle_busy", 32'(cal_busy), 32'd0);
        check("idle_band", 32'(band), 32'h80);

        run_cal(8'h5A, 4, 3, 1'b0, "plan");
        run_cal(8'hFF, 0, 1, 1'b0, "top");
        run_cal(8'h00, 0, 1, 1'b0, "bottom");
        for (int i = 0; i < 6; i++) begin
            run_cal(8'($urandom_range(0, 255)), int'($urandom_range(0, 5)),
                    int'($urandom_range(1, 4)), 1'b0, $sformatf("rand%0d", i));
        end
        run_cal(8'($urandom_range(0, 255)), 4, 3, 1'b1, "noise");

        // Comparator silent: the search must time out to the mid band.
        resp_on = 1'b0;
        csr_flb_cal_settle = 8'd2;
        @(negedge ref_clk);
        csr_flb_cal_start = 1'b1;
        t_req = -1;
        t_err = -1;
        for (int cyc = 0; cyc < 1500 && t_err < 0; cyc++) begin
            @(negedge ref_clk);
            if (cal_busy) csr_flb_cal_start = 1'b0;
            if (meas_req && t_req < 0) t_req = cyc;
            if (cal_err) t_err = cyc;
        end
        csr_flb_cal_start = 1'b0;
        check("tmo_len", 32'(t_err - t_req), 32'(TMO + 1));
        check("tmo_band", 32'(band), 32'h80);
        check("tmo_hold", 32'(dlf_hold), 32'd1);
        check("tmo_gate", 32'(sdm_gate), 32'd0);
        check("tmo_busy", 32'(cal_busy), 32'd0);
        resp_on = 1'b1;
        run_cal(8'($urandom_range(0, 255)), 1, 2, 1'b0, "retry");

        // Manual override at bit 4.
        target = 8'($urandom_range(0, 255));
        d_cyc = 2;
        csr_flb_cal_settle = 8'd2;
        start_until_reqs(4);
        check("man_reach", 32'(reqs), 32'd4);
        csr_flb_cal_man_band = 8'h3C;
        csr_flb_cal_man_on   = 1'b1;
        @(posedge ref_clk);
        #1;
        check("man_band", 32'(band), 32'h3C);
        check("man_gate", 32'(sdm_gate), 32'd1);
        check("man_hold", 32'(dlf_hold), 32'd0);
        check("man_busy", 32'(cal_busy), 32'd0);
        check("man_done", 32'(cal_done), 32'd0);
        @(negedge ref_clk);
        csr_flb_cal_man_band = 8'hC5;
        @(posedge ref_clk);
        #1;
        check("man_follow", 32'(band), 32'hC5);
        @(negedge ref_clk);
        csr_flb_cal_man_band = 8'h3C;
        @(negedge ref_clk);
        csr_flb_cal_man_on   = 1'b0;
        csr_flb_cal_man_band = 8'h11;
        @(posedge ref_clk);
        #1;
        check("rel_band", 32'(band), 32'h3C);
        check("rel_hold", 32'(dlf_hold), 32'd1);
        check("rel_gate", 32'(sdm_gate), 32'd0);
        repeat (6) @(negedge ref_clk);
        check("rel_idle_busy", 32'(cal_busy), 32'd0);
        check("rel_idle_band", 32'(band), 32'h3C);

        // Asynchronous reset in the middle of WAIT.
        target = 8'($urandom_range(0, 255));
        d_cyc = 4;
        csr_flb_cal_settle = 8'd2;
        start_until_reqs(3);
        check("arst_reach", 32'(reqs), 32'd3);
        @(posedge ref_clk);
        #2 csr_flb_rst_n = 1'b0;
        #1;
        check("arst_band", 32'(band), 32'h80);
        check("arst_req", 32'(meas_req), 32'd0);
        check("arst_hold", 32'(dlf_hold), 32'd1);
        check("arst_gate", 32'(sdm_gate), 32'd0);
        check("arst_busy", 32'(cal_busy), 32'd0);
        glitch = 0;
        repeat (3) begin
            @(negedge ref_clk);
            if (meas_req !== 1'b0) glitch++;
        end
        check("arst_no_req", 32'(glitch), 32'd0);
        csr_flb_rst_n = 1'b1;
        repeat (8) @(negedge ref_clk);
        run_cal(8'($urandom_range(0, 255)), 3, 2, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flb_band_cal_ctrl.md
# flb_band_cal_ctrl

Successive-approximation band calibration controller for the FLB. After reset or on request, it searches the 8-bit coarse `band` code MSB-first and judges each trial with an external DCO-vs-target frequency comparator. It holds the DLF and gates the FLB sigma-delta during the search, then hands the loop over to fine tracking. It runs in the `ref_clk` domain and drives the FLB `band` input directly.

## Interface
- `BAND_W`, default 8: band code width.
- `SETTLE_W`, default 8: settle-count CSR width.
- `TMO_CYC`, default 1023: maximum `ref_clk` cycles spent waiting for `meas_valid`.
- `ref_clk`  in  1: single clock, rising edge.
- `csr_flb_rst_n`  in  1: asynchronous active-low reset.
- `csr_flb_cal_start`  in  1: calibration request, rising-edge sensitive.
- `csr_flb_cal_settle`  in  SETTLE_W: cycles to wait after each band change; 0 is treated as 1.
- `csr_flb_cal_man_on`  in  1: manual band override.
- `csr_flb_cal_man_band`  in  BAND_W: manual band value.
- `meas_valid`  in  1: comparator result strobe.
- `meas_fast`  in  1: DCO above target; qualified only by `meas_valid`.
- `meas_req`  out  1: one-cycle measurement request.
- `band`  out  BAND_W: band code to the FLB. A higher code gives a higher frequency.
- `dlf_hold`  out  1: freezes the DLF integrator.
- `sdm_gate`  out  1: ANDed with `csr_flb_sdm_on` at the FLB.
- `cal_busy`, `cal_done`, `cal_err`  out  1 each: status.

## Operation
- States:
  - IDLE: waits for a request.
  - SETTLE: counts down the settle time.
  - REQ: issues the measurement request.
  - WAIT: waits for the comparator result.
  - DONE: calibration complete.
  - ERR: measurement timeout.
  - MAN: manual override active.
- IDLE/DONE/ERR → SETTLE on a start rising edge:
  - result is cleared.
  - bit index is set to BAND_W-1.
  - `band` is set to trial = result | (1<<idx).
- SETTLE: counts max(settle,1) cycles, then goes to REQ.
- REQ: drives `meas_req`=1 for exactly one cycle, then goes to WAIT.
- WAIT, on `meas_valid`:
  - if `meas_fast`=1, the bit is cleared; otherwise it is kept.
  - if idx>0: decrement idx, register the new trial on `band`, go to SETTLE.
  - if idx=0: `band` = final result, go to DONE.
- WAIT timeout: after TMO_CYC cycles without `meas_valid`, go to ERR.
- `meas_valid` outside WAIT, including the REQ cycle, is ignored.
- Start edges seen while in SETTLE, REQ or WAIT are ignored; no queueing.
- `csr_flb_cal_man_on`=1 forces MAN from any state, overriding start in the same cycle:
  - `band` = `csr_flb_cal_man_band`, updated every cycle.
  - `dlf_hold`=0, `sdm_gate`=1, all status outputs 0.
  - Falling `csr_flb_cal_man_on` → IDLE with `band` unchanged.
- Outputs per state:
  - IDLE: `dlf_hold`=1, `sdm_gate`=0.
  - SETTLE/REQ/WAIT: `cal_busy`=1, `dlf_hold`=1, `sdm_gate`=0.
  - DONE: `cal_done`=1, `dlf_hold`=0, `sdm_gate`=1.
  - ERR: `cal_err`=1, `band`=BAND_MID (8'h80), `dlf_hold`=1, `sdm_gate`=0.
- All outputs are registered.

## Timing
- Reset values (asynchronous):
  - state IDLE.
  - `band`=8'h80.
  - `meas_req`=0, `dlf_hold`=1, `sdm_gate`=0.
  - `cal_busy`=`cal_done`=`cal_err`=0.
  - internal start-edge history = 0.
- Reset mid-search discards the partial result immediately.
- Start edge: the edge is detected on the registered start sample. SETTLE is entered on the clock after the cycle in which `csr_flb_cal_start` is first sampled high.
- Per bit: S+1+d cycles, where S = max(settle,1) and d = cycles from the `meas_req` cycle to the `meas_valid` cycle (d≥1).
- `cal_done` rises 8·(S+1+d) cycles after SETTLE is first entered.
- The timeout counter restarts on every WAIT entry. ERR is entered on the edge after TMO_CYC WAIT cycles.
- Settle and timeout counters saturate; they never wrap.

## Structure
- `flb_pkg` holds:
  - the `flb_cal_state_e` enum.
  - `BAND_MID`.
  - default widths BAND_W and SETTLE_W.
- One sub-module, `flb_cal_timer`: a loadable down-counter with a `zero` flag, shared for settle and timeout. The load value is selected by state.
- The top level contains the FSM, the SAR result/index registers and the start edge detector.

## Test plan
- Comparator model fast = (band > 8'h5A), d=3, settle=4 → 8 `meas_req` pulses; final `band`=8'h5A; `cal_done` rises exactly 64 cycles after the first SETTLE entry; `dlf_hold` falls and `sdm_gate` rises in that same cycle.
- Targets 8'hFF and 8'h00, settle=0 → results 8'hFF and 8'h00; settle phase lasts 1 cycle per bit.
- Comparator never returns valid → `cal_err`=1 after TMO_CYC cycles of WAIT; `band`=8'h80; a new start edge restarts the search cleanly.
- Start toggled during a search, plus `meas_valid` pulsed in the REQ cycle and in SETTLE → both ignored; search result unchanged.
- `csr_flb_cal_man_on`=1 at bit 4 with `csr_flb_cal_man_band`=8'h3C → next cycle `band`=8'h3C, `sdm_gate`=1, `cal_busy`=0; release → IDLE with `band` held at 8'h3C.
- `csr_flb_rst_n` asserted mid-WAIT → asynchronous return to reset values with no `meas_req` glitch; a subsequent full search is correct.
